// File: rtl/sik_encoder_if.sv
// Instruction-stream handshake between a program loader and the SIK encoder.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; while ready is low the producer may change its payload freely, only the value present on the transfer edge is taken, and ready may depend combinationally on the consumer's downstream ready.
interface sik_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_ext;
    logic [3:0]  in_op;
    logic [15:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_word;
    logic        out_is_pre;

    modport master (
        output in_valid, in_ext, in_op, in_imm, out_ready,
        input  in_ready, out_valid, out_word, out_is_pre
    );

    modport slave (
        input  in_valid, in_ext, in_op, in_imm, out_ready,
        output in_ready, out_valid, out_word, out_is_pre
    );
endinterface

// File: rtl/sik_encoder.sv
// Streaming SIK instruction encoder: turns {ext, op, imm} into 16-bit fetch words,
// inserting a pre prefix when the immediate does not fit a sign-extended 12-bit field.
module sik_encoder #(
    parameter bit FORCE_PRE = 1'b0,
    parameter int ERRW      = 8
) (
    input  logic            clk,
    input  logic            reset,
    sik_encoder_if.slave    bus,
    output logic            err,
    output logic [ERRW-1:0] err_count,
    output logic [1:0]      dbg_state
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_PRE   = 2'd1,
        ST_MAIN  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     hold_word_q, hold_word_d;
    logic [15:0]     out_word_q, out_word_d;
    logic            out_is_pre_q, out_is_pre_d;
    logic            out_valid_q, out_valid_d;
    logic            err_q, err_d;
    logic [ERRW-1:0] err_count_q, err_count_d;

    logic            in_legal;
    logic            in_fits;
    logic            in_needs_pre;
    logic            in_ready;
    logic            accept;
    logic [15:0]     in_main_word;
    logic [15:0]     in_pre_word;

    always_comb begin
        in_legal     = bus.in_ext ? (bus.in_op >= 4'h1 && bus.in_op <= 4'hC)
                                  : (bus.in_op >= 4'h1 && bus.in_op <= 4'h8);
        // imm fits when bits 15..11 are all copies of the 12-bit sign bit
        in_fits      = (bus.in_imm[15:11] == 5'b00000) || (bus.in_imm[15:11] == 5'b11111);
        in_needs_pre = !bus.in_ext && in_legal && (FORCE_PRE || !in_fits);
        in_main_word = bus.in_ext ? {12'h000, bus.in_op} : {bus.in_op, bus.in_imm[11:0]};
        in_pre_word  = {4'hF, 8'h00, bus.in_imm[15:12]};
        in_ready     = (state_q == ST_EMPTY) || (state_q == ST_MAIN && bus.out_ready);
        accept       = bus.in_valid && in_ready;
    end

    always_comb begin
        state_d      = state_q;
        hold_word_d  = hold_word_q;
        out_word_d   = out_word_q;
        out_is_pre_d = out_is_pre_q;
        out_valid_d  = out_valid_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;

        case (state_q)
            ST_PRE: begin
                if (bus.out_ready) begin
                    state_d      = ST_MAIN;
                    out_word_d   = hold_word_q;
                    out_is_pre_d = 1'b0;
                end
            end
            ST_MAIN: begin
                if (bus.out_ready) begin
                    state_d      = ST_EMPTY;
                    out_valid_d  = 1'b0;
                    out_is_pre_d = 1'b0;
                end
            end
            default: ;
        endcase

        // accept only happens from EMPTY or a completing MAIN, so it overrides the above
        if (accept) begin
            if (!in_legal) begin
                state_d      = ST_EMPTY;
                out_valid_d  = 1'b0;
                out_is_pre_d = 1'b0;
                err_d        = 1'b1;
                if (err_count_q != {ERRW{1'b1}}) begin
                    err_count_d = err_count_q + ERRW'(1);
                end
            end else if (in_needs_pre) begin
                state_d      = ST_PRE;
                hold_word_d  = in_main_word;
                out_word_d   = in_pre_word;
                out_is_pre_d = 1'b1;
                out_valid_d  = 1'b1;
            end else begin
                state_d      = ST_MAIN;
                hold_word_d  = in_main_word;
                out_word_d   = in_main_word;
                out_is_pre_d = 1'b0;
                out_valid_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_EMPTY;
            hold_word_q  <= 16'h0000;
            out_word_q   <= 16'h0000;
            out_is_pre_q <= 1'b0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            hold_word_q  <= hold_word_d;
            out_word_q   <= out_word_d;
            out_is_pre_q <= out_is_pre_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_word   = out_word_q;
    assign bus.out_is_pre = out_is_pre_q;
    assign err            = err_q;
    assign err_count      = err_count_q;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_sik_encoder.sv
// Bench for sik_encoder: vector table, hand-written corner sequences and a
// randomized stream checked against a queue-based reference model.
module tb_sik_encoder;
    localparam int ERRW    = 8;
    localparam int ERR_MAX = (1 << ERRW) - 1;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ext = 1'b0;
    logic [3:0]      in_op = 4'h0;
    logic [15:0]     in_imm = 16'h0000;
    logic            out_ready = 1'b1;
    logic            err, err2;
    logic [ERRW-1:0] err_count, err_count2;
    logic [1:0]      dbg_state, dbg_state2;

    sik_encoder_if ifc ();
    sik_encoder_if ifc2 ();

    assign ifc.in_valid   = in_valid;
    assign ifc.in_ext     = in_ext;
    assign ifc.in_op      = in_op;
    assign ifc.in_imm     = in_imm;
    assign ifc.out_ready  = out_ready;
    assign ifc2.in_valid  = in_valid;
    assign ifc2.in_ext    = in_ext;
    assign ifc2.in_op     = in_op;
    assign ifc2.in_imm    = in_imm;
    assign ifc2.out_ready = out_ready;

    sik_encoder #(.FORCE_PRE(1'b0), .ERRW(ERRW)) dut (
        .clk(clk), .reset(reset), .bus(ifc),
        .err(err), .err_count(err_count), .dbg_state(dbg_state)
    );

    sik_encoder #(.FORCE_PRE(1'b1), .ERRW(ERRW)) dut_fp (
        .clk(clk), .reset(reset), .bus(ifc2),
        .err(err2), .err_count(err_count2), .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ext;
        logic [3:0]  op;
        logic [15:0] imm;
        int          n;
        logic [15:0] w0, w1;
        int          fn;
        logic [15:0] f0, f1;
    } vec_t;

    vec_t        tbl[20];
    logic [16:0] exp_q[$];
    logic [16:0] seen_q[$];
    logic [16:0] seen2_q[$];
    int          seen_t_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          err_seen = 0;
    int          cnt_model = 0;
    bit          err_exp = 0;
    bit          chk_en = 0;
    bit          rnd_stop = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
        end
    endtask

    // Reference: words for one instruction straight from the ISA rules.
    function automatic void model(input logic e, input logic [3:0] op, input logic [15:0] imm,
                                  output bit legal, output int n,
                                  output logic [16:0] w0, output logic [16:0] w1);
        int sv = $signed(imm);
        int opi = int'(op);
        legal = e ? (opi >= 1 && opi <= 12) : (opi >= 1 && opi <= 8);
        n  = 0;
        w0 = '0;
        w1 = '0;
        if (!legal) return;
        if (e) begin
            n  = 1;
            w0 = {1'b0, 12'h000, op};
        end else if (sv < -2048 || sv > 2047) begin
            n  = 2;
            w0 = {1'b1, 4'hF, 8'h00, imm[15:12]};
            w1 = {1'b0, op, imm[11:0]};
        end else begin
            n  = 1;
            w0 = {1'b0, op, imm[11:0]};
        end
    endfunction

    task automatic monitor_step();
        bit          exp_rdy, legal;
        int          n;
        logic [16:0] w0, w1;
        cyc++;
        if (ifc2.out_valid && out_ready) seen2_q.push_back({ifc2.out_is_pre, ifc2.out_word});
        if (!chk_en) begin
            exp_q.delete();
            err_exp   = 0;
            cnt_model = 0;
            return;
        end
        exp_rdy = (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready);
        check("in_ready", ifc.in_ready, exp_rdy);
        check("out_valid", ifc.out_valid, exp_q.size() != 0);
        if (ifc.out_valid && exp_q.size() != 0)
            check("out_word", {ifc.out_is_pre, ifc.out_word}, exp_q[0]);
        if (ifc.out_valid && out_ready) begin
            seen_q.push_back({ifc.out_is_pre, ifc.out_word});
            seen_t_q.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
        check("err", err, err_exp);
        check("err_count", err_count, cnt_model);
        if (err) err_seen++;
        err_exp = 0;
        if (in_valid && ifc.in_ready) begin
            model(in_ext, in_op, in_imm, legal, n, w0, w1);
            if (!legal) begin
                err_exp = 1;
                if (cnt_model < ERR_MAX) cnt_model++;
            end
            if (n >= 1) exp_q.push_back(w0);
            if (n == 2) exp_q.push_back(w1);
        end
    endtask

    task automatic do_reset();
        chk_en   = 0;
        in_valid = 0;
        reset    = 1;
        @(negedge clk);
        @(posedge clk);
        #1;
        reset  = 0;
        chk_en = 1;
    endtask

    task automatic send(input logic e, input logic [3:0] op, input logic [15:0] imm, input bit scramble);
        bit acc = 0;
        in_valid = 1;
        in_ext   = e;
        in_op    = op;
        in_imm   = imm;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = ifc.in_ready;
            @(posedge clk);
            #1;
            if (!acc && scramble) begin
                in_ext = 1'($urandom_range(0, 1));
                in_op  = 4'($urandom_range(0, 15));
                in_imm = 16'($urandom);
            end
        end
        in_valid = 0;
        check("send_accept", acc, 1);
    endtask

    task automatic drain();
        bit idle = 0;
        in_valid = 0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(posedge clk);
            #1;
            idle = (exp_q.size() == 0) && !ifc.out_valid && !ifc2.out_valid;
        end
        check("drain", idle, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int          s0, s2, e0, k;
        logic        e;
        logic [3:0]  op;
        logic [15:0] imm;
        logic [15:0] edge_imm[6];

        tbl[0]  = '{1'b0, 4'h8, 16'h0005, 1, 16'h8005, 16'h0000, 2, 16'hF000, 16'h8005};
        tbl[1]  = '{1'b0, 4'h8, 16'h1234, 2, 16'hF001, 16'h8234, 2, 16'hF001, 16'h8234};
        tbl[2]  = '{1'b0, 4'h1, 16'hFFFF, 1, 16'h1FFF, 16'h0000, 2, 16'hF00F, 16'h1FFF};
        tbl[3]  = '{1'b1, 4'h1, 16'h0000, 1, 16'h0001, 16'h0000, 1, 16'h0001, 16'h0000};
        tbl[4]  = '{1'b1, 4'h7, 16'h5555, 1, 16'h0007, 16'h0000, 1, 16'h0007, 16'h0000};
        tbl[5]  = '{1'b1, 4'h8, 16'h0000, 1, 16'h0008, 16'h0000, 1, 16'h0008, 16'h0000};
        tbl[6]  = '{1'b0, 4'h6, 16'h0010, 1, 16'h6010, 16'h0000, 2, 16'hF000, 16'h6010};
        tbl[7]  = '{1'b0, 4'h8, 16'h0800, 2, 16'hF000, 16'h8800, 2, 16'hF000, 16'h8800};
        tbl[8]  = '{1'b0, 4'h4, 16'hF800, 1, 16'h4800, 16'h0000, 2, 16'hF00F, 16'h4800};
        tbl[9]  = '{1'b0, 4'h7, 16'hF7FF, 2, 16'hF00F, 16'h77FF, 2, 16'hF00F, 16'h77FF};
        tbl[10] = '{1'b1, 4'hC, 16'hABCD, 1, 16'h000C, 16'h0000, 1, 16'h000C, 16'h0000};
        tbl[11] = '{1'b0, 4'h3, 16'h07FF, 1, 16'h37FF, 16'h0000, 2, 16'hF000, 16'h37FF};
        tbl[12] = '{1'b0, 4'h9, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[13] = '{1'b1, 4'hE, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[14] = '{1'b0, 4'h0, 16'h0001, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[15] = '{1'b0, 4'hF, 16'h0123, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[16] = '{1'b1, 4'h0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[17] = '{1'b1, 4'hD, 16'h0000, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000};
        tbl[18] = '{1'b1, 4'h5, 16'h8000, 1, 16'h0005, 16'h0000, 1, 16'h0005, 16'h0000};
        tbl[19] = '{1'b0, 4'h2, 16'h8000, 2, 16'hF008, 16'h2000, 2, 16'hF008, 16'h2000};
        edge_imm = '{16'h07FF, 16'h0800, 16'hF800, 16'hF7FF, 16'h0000, 16'hFFFF};

        fork
            forever begin
                @(negedge clk);
                monitor_step();
            end
        join_none

        // Reset state
        do_reset();
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_word", ifc.out_word, 16'h0000);
        check("rst_out_is_pre", ifc.out_is_pre, 0);
        check("rst_err", err, 0);
        check("rst_err_count", err_count, 0);
        check("rst_in_ready", ifc.in_ready, 1);

        // Vector table, one instruction at a time, both FORCE_PRE settings
        out_ready = 1;
        foreach (tbl[i]) begin
            s0 = seen_q.size();
            s2 = seen2_q.size();
            send(tbl[i].ext, tbl[i].op, tbl[i].imm, 0);
            drain();
            check($sformatf("tbl%0d_count", i), seen_q.size() - s0, tbl[i].n);
            if (seen_q.size() - s0 == tbl[i].n && tbl[i].n >= 1)
                check($sformatf("tbl%0d_w0", i), seen_q[s0], {tbl[i].n == 2, tbl[i].w0});
            if (seen_q.size() - s0 == tbl[i].n && tbl[i].n == 2)
                check($sformatf("tbl%0d_w1", i), seen_q[s0+1], {1'b0, tbl[i].w1});
            check($sformatf("tbl%0d_fp_count", i), seen2_q.size() - s2, tbl[i].fn);
            if (seen2_q.size() - s2 == tbl[i].fn && tbl[i].fn >= 1)
                check($sformatf("tbl%0d_fp_w0", i), seen2_q[s2], {tbl[i].fn == 2, tbl[i].f0});
            if (seen2_q.size() - s2 == tbl[i].fn && tbl[i].fn == 2)
                check($sformatf("tbl%0d_fp_w1", i), seen2_q[s2+1], {1'b0, tbl[i].f1});
        end

        // in_ready stays low during the prefix word, rises with the main word
        send(1'b0, 4'h8, 16'h1234, 0);
        check("pfx_word0", {ifc.out_is_pre, ifc.out_word}, {1'b1, 16'hF001});
        check("pfx_ready0", ifc.in_ready, 0);
        @(posedge clk);
        #1;
        check("pfx_word1", {ifc.out_is_pre, ifc.out_word}, {1'b0, 16'h8234});
        check("pfx_ready1", ifc.in_ready, 1);
        drain();

        // Back-to-back extended ops on consecutive cycles
        s0 = seen_q.size();
        send(1'b1, 4'h1, 16'h0000, 0);
        send(1'b1, 4'h7, 16'h0000, 0);
        send(1'b1, 4'h8, 16'h0000, 0);
        drain();
        check("b2b_count", seen_q.size() - s0, 3);
        if (seen_q.size() - s0 == 3) begin
            check("b2b_w0", seen_q[s0], 17'h00001);
            check("b2b_w1", seen_q[s0+1], 17'h00007);
            check("b2b_w2", seen_q[s0+2], 17'h00008);
            check("b2b_gap0", seen_t_q[s0+1] - seen_t_q[s0], 1);
            check("b2b_gap1", seen_t_q[s0+2] - seen_t_q[s0+1], 1);
        end

        // Back-pressure holds the prefix word stable
        out_ready = 0;
        s0 = seen_q.size();
        send(1'b0, 4'h8, 16'h0800, 0);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", ifc.out_valid, 1);
            check("bp_word", {ifc.out_is_pre, ifc.out_word}, {1'b1, 16'hF000});
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        drain();
        check("bp_count", seen_q.size() - s0, 2);
        if (seen_q.size() - s0 == 2) begin
            check("bp_w0", seen_q[s0], {1'b1, 16'hF000});
            check("bp_w1", seen_q[s0+1], {1'b0, 16'h8800});
        end

        // Illegal instructions are dropped with an error pulse each
        do_reset();
        s0 = seen_q.size();
        e0 = err_seen;
        send(1'b0, 4'h9, 16'h0001, 0);
        send(1'b1, 4'hE, 16'h0000, 0);
        drain();
        check("ill_err_count", err_count, 2);
        check("ill_pulses", err_seen - e0, 2);
        check("ill_no_words", seen_q.size() - s0, 0);
        send(1'b0, 4'h8, 16'h0001, 0);
        drain();
        check("ill_next_count", seen_q.size() - s0, 1);
        if (seen_q.size() - s0 == 1) check("ill_next_word", seen_q[s0], {1'b0, 16'h8001});

        // Reset while a prefixed instruction is stalled in PRE
        out_ready = 0;
        send(1'b0, 4'h8, 16'h1234, 0);
        @(posedge clk);
        #1;
        do_reset();
        check("mid_rst_valid", ifc.out_valid, 0);
        check("mid_rst_err_count", err_count, 0);
        check("mid_rst_word", ifc.out_word, 16'h0000);
        out_ready = 1;
        s0 = seen_q.size();
        send(1'b0, 4'h6, 16'h0010, 0);
        drain();
        check("mid_rst_count", seen_q.size() - s0, 1);
        if (seen_q.size() - s0 == 1) check("mid_rst_jump", seen_q[s0], {1'b0, 16'h6010});

        // Error counter saturates
        for (int i = 0; i < ERR_MAX + 5; i++) send(1'b0, 4'hA, 16'h0000, 0);
        drain();
        check("sat_err_count", err_count, ERR_MAX);

        // Randomized stream with random back-pressure
        do_reset();
        rnd_stop = 0;
        fork
            while (!rnd_stop) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        for (k = 0; k < 500; k++) begin
            e = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) op = 4'($urandom_range(0, 15));
            else op = e ? 4'($urandom_range(1, 12)) : 4'($urandom_range(1, 8));
            case ($urandom_range(0, 3))
                0:       imm = 16'($urandom_range(0, 2047));
                1:       imm = 16'hF800 + 16'($urandom_range(0, 2047));
                2:       imm = 16'($urandom);
                default: imm = edge_imm[$urandom_range(0, 5)];
            endcase
            send(e, op, imm, 1);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_stop = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1;
        drain();
        check("rnd_final_err_count", err_count, cnt_model);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/sik_encoder.md
Name: sik_encoder

Overview:
- Streaming instruction encoder for the SIK stack ISA. It is the write-side counterpart of the processor's decode stage.
- It accepts symbolic instructions (normal/extended opcode plus a 16-bit immediate) over a valid/ready handshake.
- It emits the 16-bit instruction words the pipelined core fetches. When an immediate does not fit 12 bits, it inserts a `pre` prefix word first.
- Used by the boot/program loader and the bench to build instruction memory images and feed them to memory.

Parameters:
- FORCE_PRE, 0, when 1 every immediate-bearing instruction gets a `pre` word, even if the immediate fits.
- ERRW, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  Clock. All state changes on the rising edge.
- reset  input  1  Reset. Synchronous, active-high.
- in_valid  input  1  Upstream instruction valid.
- in_ready  output  1  Encoder can accept this cycle.
- in_ext  input  1  1 means extended op (add/lt/sub/and/or/xor/dup/ret/sys/load/store/test). 0 means normal op.
- in_op  input  4  Opcode, normal or extended encoding.
- in_imm  input  16  Immediate. Ignored for extended ops.
- out_valid  output  1  out_word is valid.
- out_ready  input  1  Downstream accepts out_word.
- out_word  output  16  Encoded instruction word.
- out_is_pre  output  1  out_word is a `pre` prefix.
- err  output  1  One-cycle pulse: an illegal instruction was accepted and dropped.
- err_count  output  ERRW  Saturating count of dropped instructions.

Behaviour:
- Word formats:
  - Normal: {op[3:0], imm[11:0]}.
  - Pre: {4'hF, 8'h00, imm[15:12]}.
  - Extended: {4'h0, 8'h00, extop[3:0]}.
- Legality:
  - Normal ops 1..8 (get, pop, put, call, jumpf, jump, jumpt, push) are legal.
  - Extended ops 1..C are legal.
  - Everything else is illegal, including normal 0, normal F, normal 9..E, and extended 0, D..F.
- needs_pre = legal normal op AND (FORCE_PRE OR imm[15:11] not all equal, i.e. not representable as a sign-extended 12-bit value).
- States: EMPTY, PRE, MAIN.
- Outputs by state:
  - EMPTY: out_valid=0.
  - PRE: out_valid=1, out_word = pre word of held instruction, out_is_pre=1.
  - MAIN: out_valid=1, out_word = main word, out_is_pre=0.
- in_ready = (state==EMPTY) OR (state==MAIN AND out_ready). It is combinational from state and out_ready.
- Accept = in_valid AND in_ready. On accept, the instruction is captured into a holding register. Next state:
  - PRE if needs_pre.
  - MAIN if legal and no pre.
  - EMPTY if illegal. Also, err=1 in the following cycle and err_count increments, saturating at all-ones.
- Latency: an instruction accepted at edge N is presented at out_valid from edge N+1 onward. With out_ready held high, throughput is 1 word/cycle (a prefixed instruction takes 2 cycles).
- PRE & out_ready → MAIN.
- MAIN & out_ready: accept → per rule above, else → EMPTY.
- Back-pressure: while out_valid=1 and out_ready=0, out_word, out_is_pre and state hold stable. No input is accepted.
- An illegal input arriving while in MAIN with out_ready=1 is accepted. The current word completes, and the next state is EMPTY.
- A pre word and its main word are never separated by another instruction's word.
- Reset (any state, including mid-PRE):
  - State goes to EMPTY, out_valid=0, out_is_pre=0, out_word=16'h0000, err=0, err_count=0, in_ready=1 after the reset edge.
  - Any held instruction is discarded.
- Opcode/immediate changes on in_* while in_ready=0 have no effect.

Test Plan:
- Short immediate: push imm=0x0005, out_ready=1 → one word 0x8005, out_is_pre=0, at cycle after accept.
- Long immediate: push imm=0x1234 → 0xF001 (out_is_pre=1) then 0x8234. Next in_ready only in the 0x8234 cycle.
- Negative immediate: get imm=0xFFFF → single word 0x1FFF. Same stimulus with FORCE_PRE=1 → 0xF00F, 0x1FFF.
- Extended and back-to-back: ext add, ext dup, ext ret with out_ready=1 → 0x0001, 0x0007, 0x0008 on consecutive cycles. Then hold out_ready=0 for 5 cycles with push 0x0800 pending (needs_pre, since imm[15:11]=00001) → 0xF000 held stable for 5 cycles, then 0xF000 and 0x8800 are accepted in order after release.
- Illegal: normal op 4'h9, then ext op 4'hE → err pulses twice, err_count=2, no out_valid. A following push 0x0001 encodes as 0x8001.
- Reset mid-operation: accept push 0x1234, assert reset while in PRE with out_ready=0 → out_valid=0 and err_count=0 next cycle. Pre-reset words are never emitted. A post-reset jump 0x0010 → 0x6010.
